// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use bubbles, jr hold, mispredict flush and
// data-memory wait states, plus a sticky timeout flag and a stall-cycle counter.
module hazard_sequencer #(
  parameter int unsigned JR_WAIT_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT    = 15,
  parameter int unsigned CNT_W          = 16,
  parameter logic [6:0]  JR_OPCODE      = 7'b1100111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       if_id_opcode,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             EX_memread,
  input  logic             Wrong_prediction,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             if_id_Write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_Write,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, JR_WAIT, MEM_WAIT} state_t;

  state_t     state, nxt_state, resume_st, nxt_resume;
  logic [3:0] jr_cnt, nxt_jr;
  logic [7:0] mem_cnt, nxt_mem;
  logic       set_timeout;
  logic       load_use;

  assign load_use = EX_memread && (id_ex_rd != '0) &&
                    ((if_id_rs1 == id_ex_rd) || (if_id_rs2 == id_ex_rd));

  always_comb begin
    PC_Write     = 1'b1;
    if_id_Write  = 1'b1;
    ex_mem_Write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    nxt_state    = state;
    nxt_resume   = resume_st;
    nxt_jr       = jr_cnt;
    nxt_mem      = mem_cnt;
    set_timeout  = 1'b0;

    if (state == MEM_WAIT) begin
      nxt_mem = mem_cnt + 8'd1;
      if (mem_ready) begin
        nxt_state = resume_st;
      end else begin
        PC_Write     = 1'b0;
        if_id_Write  = 1'b0;
        ex_mem_Write = 1'b0;
        if (mem_cnt == 8'(MEM_TIMEOUT)) begin
          set_timeout = 1'b1;
          nxt_state   = resume_st;
        end
      end
    end else if (mem_req && !mem_ready) begin
      PC_Write     = 1'b0;
      if_id_Write  = 1'b0;
      ex_mem_Write = 1'b0;
      nxt_state    = MEM_WAIT;
      nxt_resume   = state;
      nxt_mem      = 8'd1;
    end else if (Wrong_prediction) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      nxt_state   = RUN;
      nxt_jr      = '0;
    end else if (state == JR_WAIT) begin
      PC_Write    = 1'b0;
      if_id_flush = 1'b1;
      nxt_jr      = jr_cnt - 4'd1;
      if (jr_cnt <= 4'd1) nxt_state = RUN;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      if_id_Write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (if_id_opcode == JR_OPCODE) begin
      PC_Write    = 1'b0;
      if_id_flush = 1'b1;
      nxt_state   = JR_WAIT;
      nxt_jr      = 4'(JR_WAIT_CYCLES);
    end

    if (rst) begin
      PC_Write     = 1'b0;
      if_id_Write  = 1'b0;
      ex_mem_Write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      resume_st   <= RUN;
      jr_cnt      <= '0;
      mem_cnt     <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state     <= nxt_state;
      resume_st <= nxt_resume;
      jr_cnt    <= nxt_jr;
      mem_cnt   <= nxt_mem;
      if (set_timeout) mem_timeout <= 1'b1;
      if (!PC_Write && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench: cycle-by-cycle vector table on a JR_WAIT_CYCLES=2 instance,
// plus a hand-written timeout/reset sequence on a MEM_TIMEOUT=3 instance.
module tb_hazard_sequencer;

  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  // outputs packed as {PC_Write, if_id_Write, if_id_flush, id_ex_flush, ex_mem_Write}
  localparam logic [4:0] NRM = 5'b11001;
  localparam logic [4:0] STL = 5'b00000;
  localparam logic [4:0] RSO = 5'b00110;
  localparam logic [4:0] BUB = 5'b00011;
  localparam logic [4:0] JRO = 5'b01101;
  localparam logic [4:0] FLS = 5'b11111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        mr, wp, mq, my;
    logic [4:0]  outs;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] if_id_opcode;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic EX_memread, Wrong_prediction, mem_req, mem_ready;

  logic a_pc, a_ifw, a_iff, a_idf, a_exw, a_to;
  logic [15:0] a_cnt;
  logic b_pc, b_ifw, b_iff, b_idf, b_exw, b_to;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.JR_WAIT_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_id_opcode(if_id_opcode), .if_id_rs1(if_id_rs1),
    .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd), .EX_memread(EX_memread),
    .Wrong_prediction(Wrong_prediction), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_Write(a_pc), .if_id_Write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
    .ex_mem_Write(a_exw), .mem_timeout(a_to), .stall_count(a_cnt)
  );

  hazard_sequencer #(.JR_WAIT_CYCLES(1), .MEM_TIMEOUT(3), .CNT_W(16)) dut_to (
    .clk(clk), .rst(rst), .if_id_opcode(if_id_opcode), .if_id_rs1(if_id_rs1),
    .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd), .EX_memread(EX_memread),
    .Wrong_prediction(Wrong_prediction), .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_Write(b_pc), .if_id_Write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
    .ex_mem_Write(b_exw), .mem_timeout(b_to), .stall_count(b_cnt)
  );

  function automatic vec_t mk(logic r, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic mr, logic wp, logic mq, logic my,
                              logic [4:0] outs, logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.mr = mr; v.wp = wp; v.mq = mq; v.my = my; v.outs = outs; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                       logic [4:0] rd, logic mr, logic wp, logic mq, logic my);
    rst = r; if_id_opcode = op; if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd;
    EX_memread = mr; Wrong_prediction = wp; mem_req = mq; mem_ready = my;
  endtask

  vec_t tbl[31];

  initial begin
    tbl[0]  = mk(1, OP_ALU, 0, 0, 0, 0, 0, 0, 0, RSO, 0);
    tbl[1]  = mk(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0, NRM, 0);
    tbl[2]  = mk(0, OP_ALU, 5, 1, 5, 1, 0, 0, 0, BUB, 0);   // load-use via rs1
    tbl[3]  = mk(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0, NRM, 1);
    tbl[4]  = mk(0, OP_ALU, 0, 0, 0, 1, 0, 0, 0, NRM, 1);   // load to x0
    tbl[5]  = mk(0, OP_ALU, 3, 7, 7, 1, 0, 0, 0, BUB, 1);   // load-use via rs2
    tbl[6]  = mk(0, OP_ALU, 3, 4, 7, 1, 0, 0, 0, NRM, 2);
    tbl[7]  = mk(0, OP_BEQ, 1, 2, 3, 0, 0, 0, 0, NRM, 2);
    tbl[8]  = mk(0, OP_JR,  1, 0, 3, 0, 0, 0, 0, JRO, 2);   // jr, 3-cycle hold
    tbl[9]  = mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, JRO, 3);
    tbl[10] = mk(0, OP_ALU, 5, 0, 5, 1, 0, 0, 0, JRO, 4);   // load-use ignored in JR_WAIT
    tbl[11] = mk(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0, NRM, 5);
    tbl[12] = mk(0, OP_JR,  1, 0, 3, 0, 0, 0, 0, JRO, 5);
    tbl[13] = mk(0, OP_ALU, 0, 0, 0, 0, 1, 0, 0, FLS, 6);   // mispredict aborts JR_WAIT
    tbl[14] = mk(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0, NRM, 6);
    tbl[15] = mk(0, OP_ALU, 5, 0, 5, 1, 1, 0, 0, FLS, 6);   // mispredict beats load-use
    tbl[16] = mk(0, OP_ALU, 1, 2, 3, 0, 1, 1, 0, STL, 6);   // mem wait beats mispredict
    tbl[17] = mk(0, OP_ALU, 1, 2, 3, 0, 1, 1, 0, STL, 7);
    tbl[18] = mk(0, OP_ALU, 5, 0, 5, 1, 0, 1, 0, STL, 8);
    tbl[19] = mk(0, OP_JR,  1, 2, 3, 0, 0, 1, 0, STL, 9);
    tbl[20] = mk(0, OP_ALU, 1, 2, 3, 0, 0, 1, 1, NRM, 10);
    tbl[21] = mk(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0, NRM, 10);
    tbl[22] = mk(0, OP_JR,  1, 0, 3, 0, 0, 0, 0, JRO, 10);
    tbl[23] = mk(0, OP_ALU, 0, 0, 0, 0, 0, 1, 0, STL, 11);  // mem wait inside JR_WAIT
    tbl[24] = mk(0, OP_ALU, 0, 0, 0, 0, 0, 1, 0, STL, 12);
    tbl[25] = mk(0, OP_ALU, 0, 0, 0, 0, 0, 1, 1, NRM, 13);
    tbl[26] = mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, JRO, 13);  // resumes with jr_cnt frozen
    tbl[27] = mk(0, OP_ALU, 0, 0, 0, 0, 0, 0, 0, JRO, 14);
    tbl[28] = mk(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0, NRM, 15);
    tbl[29] = mk(1, OP_ALU, 1, 2, 3, 0, 0, 0, 0, RSO, 15);
    tbl[30] = mk(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0, NRM, 0);

    drive(1, OP_ALU, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].mr, tbl[i].wp, tbl[i].mq, tbl[i].my);
      #1;
      check($sformatf("v%0d outs", i), {27'd0, a_pc, a_ifw, a_iff, a_idf, a_exw},
            {27'd0, tbl[i].outs});
      check($sformatf("v%0d stall_count", i), {16'd0, a_cnt}, {16'd0, tbl[i].cnt});
      check($sformatf("v%0d mem_timeout", i), {31'd0, a_to}, 32'd0);
    end

    // Timeout on the MEM_TIMEOUT=3 instance: entry cycle plus three wait cycles.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, OP_ALU, 1, 2, 3, 0, 0, 1, 0);
      #1;
      check($sformatf("to c%0d outs", c), {27'd0, b_pc, b_ifw, b_iff, b_idf, b_exw},
            {27'd0, STL});
      check($sformatf("to c%0d mem_timeout", c), {31'd0, b_to}, 32'd0);
    end
    @(negedge clk);
    drive(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0);
    #1;
    check("to set", {31'd0, b_to}, 32'd1);
    check("to stall_count", {16'd0, b_cnt}, 32'd4);
    check("to exit outs", {27'd0, b_pc, b_ifw, b_iff, b_idf, b_exw}, {27'd0, NRM});
    @(negedge clk);
    #1;
    check("to sticky", {31'd0, b_to}, 32'd1);
    @(negedge clk);
    drive(1, OP_ALU, 1, 2, 3, 0, 0, 0, 0);
    #1;
    check("to rst outs", {27'd0, b_pc, b_ifw, b_iff, b_idf, b_exw}, {27'd0, RSO});
    @(negedge clk);
    drive(0, OP_ALU, 1, 2, 3, 0, 0, 0, 0);
    #1;
    check("to cleared", {31'd0, b_to}, 32'd0);
    check("to cnt cleared", {16'd0, b_cnt}, 32'd0);
    check("to run outs", {27'd0, b_pc, b_ifw, b_iff, b_idf, b_exw}, {27'd0, NRM});
    @(negedge clk);
    drive(0, OP_JR, 1, 0, 3, 0, 0, 0, 0);
    #1;
    check("to jr decode in RUN", {27'd0, b_pc, b_ifw, b_iff, b_idf, b_exw}, {27'd0, JRO});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
